lsu_ctrl: RTL and testbench

- Parametrised multi-cycle load/store unit that replaces the purely combinational memory stage.
- Sits between EX and WB.
- Accepts one memory or pass-through operation per handshake and issues byte-strobed bus transactions (no read-modify-write for stores).
- Aligns and extends load data, detects misaligned accesses, and stalls the pipeline via hold_flag_o while a bus transaction is outstanding.
- Results are registered toward WB.

---
 rtl/lsu_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit between EX and WB. It issues byte-strobed bus
// requests, aligns and extends load data, drops misaligned accesses and stalls EX.
module lsu_ctrl #(
  parameter int XLEN    = 64,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic               ex_is_load_i,
  input  logic               ex_is_store_i,
  input  logic [2:0]         ex_funct3_i,
  input  logic [AW-1:0]      ex_addr_i,
  input  logic [XLEN-1:0]    ex_sdata_i,
  input  logic [RADDR_W-1:0] ex_wd_i,
  input  logic               ex_wreg_i,
  input  logic [XLEN-1:0]    ex_wdata_i,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [AW-1:0]      bus_addr_o,
  output logic [DW-1:0]      bus_wdata_o,
  output logic [DW/8-1:0]    bus_wstrb_o,
  input  logic               bus_gnt_i,
  input  logic               bus_rvalid_i,
  input  logic [DW-1:0]      bus_rdata_i,
  output logic               wb_valid_o,
  output logic [RADDR_W-1:0] wb_wd_o,
  output logic               wb_wreg_o,
  output logic [XLEN-1:0]    wb_wdata_o,
  output logic               misalign_o,
  output logic               hold_flag_o
);

  localparam int NB      = DW / 8;
  localparam int OFF_W   = $clog2(NB);
  localparam bit WIDE_OK = (XLEN == 64) && (DW == 64);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  // Undefined encodings and 64-bit accesses on a narrow configuration count as misaligned.
  function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                     input logic [OFF_W-1:0] off);
    logic             legal;
    logic [OFF_W-1:0] mask;
    if (is_load) begin
      legal = (f3 != 3'b111) && ((f3 != 3'b110) || (XLEN == 64));
    end else begin
      legal = (f3[2] == 1'b0);
    end
    legal = legal && ((f3[1:0] != 2'b11) || WIDE_OK);
    case (f3[1:0])
      2'b00:   mask = '0;
      2'b01:   mask = OFF_W'(3'd1);
      2'b10:   mask = OFF_W'(3'd3);
      default: mask = OFF_W'(3'd7);
    endcase
    return legal && ((off & mask) == '0);
  endfunction

  function automatic logic [NB-1:0] strb_of(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [NB-1:0] base;
    case (sz)
      2'b00:   base = NB'(8'h01);
      2'b01:   base = NB'(8'h03);
      2'b10:   base = NB'(8'h0F);
      default: base = NB'(8'hFF);
    endcase
    return base << off;
  endfunction

  state_e             state_q, state_d;
  logic               is_load_q, is_load_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [RADDR_W-1:0] wd_q, wd_d;
  logic               wreg_q, wreg_d;
  logic [AW-1:0]      req_addr_q, req_addr_d;
  logic               req_we_q, req_we_d;
  logic [DW-1:0]      req_wdata_q, req_wdata_d;
  logic [NB-1:0]      req_wstrb_q, req_wstrb_d;
  logic               wb_valid_q, wb_valid_d;
  logic [RADDR_W-1:0] wb_wd_q, wb_wd_d;
  logic               wb_wreg_q, wb_wreg_d;
  logic [XLEN-1:0]    wb_wdata_q, wb_wdata_d;
  logic               misalign_q, misalign_d;

  logic [OFF_W-1:0]   ex_off_s;
  logic               ex_mem_s, ex_ok_s, accept_mem_s, resp_s;
  logic [DW-1:0]      sdata_ext_s, rdata_shift_s;
  logic [XLEN-1:0]    load_val_s;

  assign ex_off_s     = ex_addr_i[OFF_W-1:0];
  assign ex_mem_s     = ex_is_load_i | ex_is_store_i;
  assign ex_ok_s      = access_ok(ex_is_load_i, ex_funct3_i, ex_off_s);
  assign accept_mem_s = (state_q == IDLE) & ex_valid_i & ex_mem_s & ex_ok_s;
  assign resp_s       = bus_rvalid_i & ((state_q == WAIT) | ((state_q == REQ) & bus_gnt_i));

  // Widen store data onto the bus and pull the addressed bytes out of the read word.
  always_comb begin
    sdata_ext_s = '0;
    sdata_ext_s[XLEN-1:0] = ex_sdata_i;
    rdata_shift_s = bus_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val_s = XLEN'($signed(rdata_shift_s[7:0]));
      3'b001:  load_val_s = XLEN'($signed(rdata_shift_s[15:0]));
      3'b010:  load_val_s = XLEN'($signed(rdata_shift_s[31:0]));
      3'b100:  load_val_s = XLEN'(rdata_shift_s[7:0]);
      3'b101:  load_val_s = XLEN'(rdata_shift_s[15:0]);
      3'b110:  load_val_s = XLEN'(rdata_shift_s[31:0]);
      default: load_val_s = rdata_shift_s[XLEN-1:0];
    endcase
  end

  // Next-state and capture logic; the WB pulse and misalign flag default low each cycle.
  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    wb_valid_d  = 1'b0;
    wb_wd_d     = wb_wd_q;
    wb_wreg_d   = wb_wreg_q;
    wb_wdata_d  = wb_wdata_q;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid_i && !ex_mem_s) begin
          wb_valid_d = 1'b1;
          wb_wd_d    = ex_wd_i;
          wb_wreg_d  = ex_wreg_i;
          wb_wdata_d = ex_wdata_i;
        end else if (ex_valid_i && !ex_ok_s) begin
          wb_valid_d = 1'b1;
          misalign_d = 1'b1;
          wb_wd_d    = ex_wd_i;
          wb_wreg_d  = 1'b0;
          wb_wdata_d = '0;
        end else if (ex_valid_i) begin
          state_d     = REQ;
          is_load_d   = ex_is_load_i;
          funct3_d    = ex_funct3_i;
          off_d       = ex_off_s;
          wd_d        = ex_wd_i;
          wreg_d      = ex_wreg_i;
          req_addr_d  = {ex_addr_i[AW-1:OFF_W], {OFF_W{1'b0}}};
          req_we_d    = ~ex_is_load_i;
          req_wdata_d = ex_is_load_i ? '0 : (sdata_ext_s << {ex_off_s, 3'b000});
          req_wstrb_d = ex_is_load_i ? '0 : strb_of(ex_funct3_i[1:0], ex_off_s);
        end else begin
          state_d = IDLE;
        end
      end
      REQ, WAIT: begin
        // A response may coincide with the grant, skipping WAIT entirely.
        if (resp_s) begin
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_wd_d    = wd_q;
          wb_wreg_d  = is_load_q & wreg_q;
          wb_wdata_d = is_load_q ? load_val_s : '0;
        end else if ((state_q == REQ) && bus_gnt_i) begin
          state_d = WAIT;
        end else begin
          state_d = state_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured operation and registered WB result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_wd_q     <= '0;
      wb_wreg_q   <= 1'b0;
      wb_wdata_q  <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      wb_valid_q  <= wb_valid_d;
      wb_wd_q     <= wb_wd_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_wdata_q  <= wb_wdata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign ex_ready_o  = (state_q == IDLE);
  assign hold_flag_o = (state_q == REQ) | (state_q == WAIT) | accept_mem_s;
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = req_we_q;
  assign bus_addr_o  = req_addr_q;
  assign bus_wdata_o = req_wdata_q;
  assign bus_wstrb_o = req_wstrb_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_wd_o     = wb_wd_q;
  assign wb_wreg_o   = wb_wreg_q;
  assign wb_wdata_o  = wb_wdata_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, hand-written reset/throughput
// sequences, and random operations checked against an arithmetic reference model.
module tb_lsu_ctrl;

  logic        clk, rst_n;
  logic        ex_valid_i, ex_ready_o, ex_is_load_i, ex_is_store_i;
  logic [2:0]  ex_funct3_i;
  logic [63:0] ex_addr_i, ex_sdata_i, ex_wdata_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic        bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
  logic [63:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [7:0]  bus_wstrb_o;
  logic        wb_valid_o, wb_wreg_o, misalign_o, hold_flag_o;
  logic [4:0]  wb_wd_o;
  logic [63:0] wb_wdata_o;

  lsu_ctrl #(.XLEN(64), .AW(64), .DW(64), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_is_load_i(ex_is_load_i), .ex_is_store_i(ex_is_store_i),
    .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i), .ex_sdata_i(ex_sdata_i),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
    .wb_wdata_o(wb_wdata_o), .misalign_o(misalign_o), .hold_flag_o(hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  string tag    = "init";

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr, sdata, wdata, rdata;
    logic [4:0]  wd;
    logic        wreg;
    int          gd;
    int          rd;
    logic        e_mis;
    logic [63:0] e_baddr;
    logic [7:0]  e_strb;
    logic [63:0] e_bwdata, e_wb;
    logic        e_wreg;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] sdata,
                              input logic [63:0] wdata, input logic [63:0] rdata,
                              input logic [4:0] wd, input logic wreg, input int gd, input int rd,
                              input logic em, input logic [63:0] eba, input logic [7:0] es,
                              input logic [63:0] ebw, input logic [63:0] ewb, input logic ew);
    vec_t t;
    t.ld = ld; t.st = st; t.f3 = f3; t.addr = addr; t.sdata = sdata; t.wdata = wdata;
    t.rdata = rdata; t.wd = wd; t.wreg = wreg; t.gd = gd; t.rd = rd;
    t.e_mis = em; t.e_baddr = eba; t.e_strb = es; t.e_bwdata = ebw; t.e_wb = ewb; t.e_wreg = ew;
    return t;
  endfunction

  // Reference: access size, byte offset and extension derived arithmetically.
  function automatic vec_t model(input vec_t t);
    vec_t        r;
    int          size, off;
    logic        legal;
    logic [63:0] m, v;
    r     = t;
    size  = 1 << t.f3[1:0];
    off   = int'(t.addr % 64'd8);
    legal = t.ld ? (t.f3 != 3'd7) : (t.f3 < 3'd4);
    r.e_mis    = (t.ld || t.st) && (!legal || (off % size) != 0);
    r.e_baddr  = t.addr - 64'(off);
    r.e_strb   = t.st ? 8'(((1 << size) - 1) << off) : 8'h00;
    r.e_bwdata = t.sdata << (8 * off);
    v = t.rdata >> (8 * off);
    if (size < 8) begin
      m = (64'd1 << (8 * size)) - 64'd1;
      v = v & m;
      if (!t.f3[2] && v[8*size-1]) v = v | ~m;
    end
    r.e_wb   = (t.ld || t.st) ? v : t.wdata;
    r.e_wreg = (t.ld || t.st) ? (t.ld && !r.e_mis && t.wreg) : t.wreg;
    return r;
  endfunction

  task automatic issue_op(input vec_t t);
    logic mem_ok;
    mem_ok = (t.ld || t.st) && !t.e_mis;
    ex_valid_i = 1'b1; ex_is_load_i = t.ld; ex_is_store_i = t.st; ex_funct3_i = t.f3;
    ex_addr_i = t.addr; ex_sdata_i = t.sdata; ex_wdata_i = t.wdata;
    ex_wd_i = t.wd; ex_wreg_i = t.wreg;
    #1;
    chk("ready_idle", 64'(ex_ready_o), 64'd1);
    chk("hold_accept", 64'(hold_flag_o), 64'(mem_ok));
    @(posedge clk); #1;
    ex_valid_i = 1'b0; ex_is_load_i = 1'b0; ex_is_store_i = 1'b0;
    if (!mem_ok) begin
      chk("wb_valid", 64'(wb_valid_o), 64'd1);
      chk("misalign", 64'(misalign_o), 64'(t.e_mis));
      chk("wb_wreg", 64'(wb_wreg_o), 64'(t.e_wreg));
      chk("wb_wd", 64'(wb_wd_o), 64'(t.wd));
      if (!t.e_mis) chk("wb_wdata", wb_wdata_o, t.e_wb);
      chk("no_req", 64'(bus_req_o), 64'd0);
      chk("no_hold", 64'(hold_flag_o), 64'd0);
    end else begin
      for (int k = 0; k <= t.gd; k++) begin
        chk("req", 64'(bus_req_o), 64'd1);
        chk("addr", bus_addr_o, t.e_baddr);
        chk("we", 64'(bus_we_o), 64'(t.st));
        chk("strb", 64'(bus_wstrb_o), 64'(t.e_strb));
        if (t.st) chk("bwdata", bus_wdata_o, t.e_bwdata);
        chk("hold_req", 64'(hold_flag_o), 64'd1);
        chk("ready_req", 64'(ex_ready_o), 64'd0);
        chk("wb_quiet_req", 64'(wb_valid_o), 64'd0);
        if (k == t.gd) begin
          bus_gnt_i = 1'b1;
          if (t.rd == 0) begin bus_rvalid_i = 1'b1; bus_rdata_i = t.rdata; end
        end
        @(posedge clk); #1;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
      end
      for (int j = 1; j <= t.rd; j++) begin
        chk("req_wait", 64'(bus_req_o), 64'd0);
        chk("hold_wait", 64'(hold_flag_o), 64'd1);
        chk("wb_quiet_wait", 64'(wb_valid_o), 64'd0);
        if (j == t.rd) begin bus_rvalid_i = 1'b1; bus_rdata_i = t.rdata; end
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0;
      end
      chk("wb_valid", 64'(wb_valid_o), 64'd1);
      chk("wb_wreg", 64'(wb_wreg_o), 64'(t.e_wreg));
      chk("wb_wd", 64'(wb_wd_o), 64'(t.wd));
      if (t.ld) chk("wb_wdata", wb_wdata_o, t.e_wb);
      chk("misalign_resp", 64'(misalign_o), 64'd0);
      chk("hold_resp", 64'(hold_flag_o), 64'd0);
      chk("ready_resp", 64'(ex_ready_o), 64'd0);
    end
    @(posedge clk); #1;
    chk("wb_single_pulse", 64'(wb_valid_o), 64'd0);
    chk("ready_after", 64'(ex_ready_o), 64'd1);
  endtask

  task automatic chk_reset_values();
    chk("rst_ready", 64'(ex_ready_o), 64'd1);
    chk("rst_hold", 64'(hold_flag_o), 64'd0);
    chk("rst_req", 64'(bus_req_o), 64'd0);
    chk("rst_we", 64'(bus_we_o), 64'd0);
    chk("rst_addr", bus_addr_o, 64'd0);
    chk("rst_strb", 64'(bus_wstrb_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_wreg", 64'(wb_wreg_o), 64'd0);
    chk("rst_wb_wdata", wb_wdata_o, 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
  endtask

  initial begin
    vec_t t;
    int   typ;
    rst_n = 1'b0; ex_valid_i = 1'b0; ex_is_load_i = 1'b0; ex_is_store_i = 1'b0;
    ex_funct3_i = 3'd0; ex_addr_i = 64'd0; ex_sdata_i = 64'd0; ex_wdata_i = 64'd0;
    ex_wd_i = 5'd0; ex_wreg_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 64'd0;

    tbl[0]  = mk(0, 0, 3'b000, 64'h0, 64'h0, 64'h1234, 64'h0, 5'd5, 1, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'h1234, 1);
    tbl[1]  = mk(1, 0, 3'b000, 64'h80000003, 64'h0, 64'h0, 64'h0000000080000000, 5'd7, 1, 0, 1, 0, 64'h80000000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 1);
    tbl[2]  = mk(1, 0, 3'b100, 64'h80000003, 64'h0, 64'h0, 64'h0000000080000000, 5'd7, 1, 1, 0, 0, 64'h80000000, 8'h00, 64'h0, 64'h80, 1);
    tbl[3]  = mk(0, 1, 3'b001, 64'h80000006, 64'hBEEF, 64'h0, 64'h0, 5'd9, 1, 3, 2, 0, 64'h80000000, 8'hC0, 64'hBEEF000000000000, 64'h0, 0);
    tbl[4]  = mk(1, 0, 3'b010, 64'h80000002, 64'h0, 64'h0, 64'h0, 5'd3, 1, 0, 0, 1, 64'h0, 8'h00, 64'h0, 64'h0, 0);
    tbl[5]  = mk(1, 0, 3'b011, 64'h80000008, 64'h0, 64'h0, 64'h0123456789ABCDEF, 5'd10, 1, 2, 1, 0, 64'h80000008, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1);
    tbl[6]  = mk(1, 0, 3'b001, 64'h80000002, 64'h0, 64'h0, 64'h0000000080010000, 5'd11, 1, 0, 0, 0, 64'h80000000, 8'h00, 64'h0, 64'hFFFFFFFFFFFF8001, 1);
    tbl[7]  = mk(1, 0, 3'b101, 64'h80000002, 64'h0, 64'h0, 64'h0000000080010000, 5'd12, 1, 1, 2, 0, 64'h80000000, 8'h00, 64'h0, 64'h8001, 1);
    tbl[8]  = mk(1, 0, 3'b010, 64'h80000004, 64'h0, 64'h0, 64'h8765432100000000, 5'd13, 1, 0, 1, 0, 64'h80000000, 8'h00, 64'h0, 64'hFFFFFFFF87654321, 1);
    tbl[9]  = mk(1, 0, 3'b110, 64'h80000004, 64'h0, 64'h0, 64'h8765432100000000, 5'd14, 0, 1, 1, 0, 64'h80000000, 8'h00, 64'h0, 64'h0000000087654321, 0);
    tbl[10] = mk(0, 1, 3'b000, 64'h1005, 64'h11223344556677AB, 64'h0, 64'h0, 5'd1, 1, 0, 0, 0, 64'h1000, 8'h20, 64'h6677AB0000000000, 64'h0, 0);
    tbl[11] = mk(0, 1, 3'b010, 64'h2004, 64'hDEADBEEF, 64'h0, 64'h0, 5'd2, 1, 2, 0, 0, 64'h2000, 8'hF0, 64'hDEADBEEF00000000, 64'h0, 0);
    tbl[12] = mk(0, 1, 3'b011, 64'h3000, 64'hCAFEF00D12345678, 64'h0, 64'h0, 5'd4, 1, 1, 1, 0, 64'h3000, 8'hFF, 64'hCAFEF00D12345678, 64'h0, 0);
    tbl[13] = mk(0, 1, 3'b011, 64'h3004, 64'h1, 64'h0, 64'h0, 5'd6, 1, 0, 0, 1, 64'h0, 8'h00, 64'h0, 64'h0, 0);
    tbl[14] = mk(0, 1, 3'b100, 64'h4000, 64'h1, 64'h0, 64'h0, 5'd8, 1, 0, 0, 1, 64'h0, 8'h00, 64'h0, 64'h0, 0);
    tbl[15] = mk(1, 0, 3'b111, 64'h5000, 64'h0, 64'h0, 64'h0, 5'd15, 1, 0, 0, 1, 64'h0, 8'h00, 64'h0, 64'h0, 0);
    tbl[16] = mk(1, 0, 3'b001, 64'h80000001, 64'h0, 64'h0, 64'h0, 5'd16, 1, 0, 0, 1, 64'h0, 8'h00, 64'h0, 64'h0, 0);
    tbl[17] = mk(0, 0, 3'b010, 64'h7, 64'h0, 64'hFEDCBA9876543210, 64'h0, 5'd31, 0, 0, 0, 0, 64'h0, 8'h00, 64'h0, 64'hFEDCBA9876543210, 0);

    #3;
    tag = "reset";
    chk_reset_values();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      tag = $sformatf("tbl%0d", i);
      issue_op(tbl[i]);
    end

    // Back-to-back pass-through: one result per cycle, never stalling.
    tag = "b2b";
    ex_valid_i = 1'b1; ex_wdata_i = 64'hAAAA; ex_wd_i = 5'd20; ex_wreg_i = 1'b1;
    @(posedge clk); #1;
    ex_wdata_i = 64'hBBBB; ex_wd_i = 5'd21;
    #1;
    chk("first_valid", 64'(wb_valid_o), 64'd1);
    chk("first_data", wb_wdata_o, 64'hAAAA);
    chk("hold", 64'(hold_flag_o), 64'd0);
    chk("ready", 64'(ex_ready_o), 64'd1);
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
    chk("second_valid", 64'(wb_valid_o), 64'd1);
    chk("second_data", wb_wdata_o, 64'hBBBB);
    chk("second_wd", 64'(wb_wd_o), 64'd21);
    @(posedge clk); #1;
    chk("end_valid", 64'(wb_valid_o), 64'd0);

    // Reset while waiting for a response; a stale response must be ignored.
    tag = "rst_wait";
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_funct3_i = 3'b011; ex_addr_i = 64'h9000;
    ex_wd_i = 5'd9; ex_wreg_i = 1'b1;
    @(posedge clk); #1;
    ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
    bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    chk("in_wait_req", 64'(bus_req_o), 64'd0);
    chk("in_wait_hold", 64'(hold_flag_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'h5555AAAA5555AAAA;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    chk("stale_valid", 64'(wb_valid_o), 64'd0);
    chk("stale_hold", 64'(hold_flag_o), 64'd0);
    chk("stale_ready", 64'(ex_ready_o), 64'd1);
    @(posedge clk); #1;
    chk("stale_valid2", 64'(wb_valid_o), 64'd0);
    tag = "after_rst";
    issue_op(tbl[8]);

    for (int i = 0; i < 200; i++) begin
      typ     = int'($urandom_range(0, 2));
      t.ld    = (typ == 1);
      t.st    = (typ == 2);
      t.f3    = 3'($urandom_range(0, 7));
      t.addr  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) t.addr = t.addr & ~64'h7;
      t.sdata = {$urandom, $urandom};
      t.wdata = {$urandom, $urandom};
      t.rdata = {$urandom, $urandom};
      t.wd    = 5'($urandom_range(0, 31));
      t.wreg  = 1'($urandom_range(0, 1));
      t.gd    = int'($urandom_range(0, 3));
      t.rd    = int'($urandom_range(0, 2));
      t       = model(t);
      tag     = $sformatf("rnd%0d", i);
      issue_op(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
